// File: rtl/axi_sram_bridge.sv
// Bridges SRAM-like inst (read-only) and data (read/write) ports to a single-outstanding AXI3 master, data wins over inst.
// Zero-wait slave: data_ok 3 cycles after addr_ok; AXI ready/valid stalls simply hold the FSM in its current state.
module axi_sram_bridge #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP, DONE} state_t;

  state_t      state, state_nxt;
  logic        owner_data;
  logic [31:0] addr_r;
  logic [1:0]  size_r;
  logic        wr_r;
  logic [3:0]  wstrb_r;
  logic [31:0] wdata_r;
  logic        aw_done, w_done;
  logic [31:0] inst_rdata_r, data_rdata_r;
  logic        accept_data, accept_inst;
  logic        aw_hs, w_hs;
  logic        unused_ok;

  // Response IDs/status are not needed with only one transaction in flight.
  assign unused_ok = ^{rid, rresp, rlast, bid, bresp, wr_r};

  assign accept_data  = (state == IDLE) && data_req;
  assign accept_inst  = (state == IDLE) && inst_req && !data_req;
  assign data_addr_ok = accept_data;
  assign inst_addr_ok = accept_inst;

  assign arid    = owner_data ? DATA_ID : INST_ID;
  assign araddr  = addr_r;
  assign arlen   = 4'd0;
  assign arsize  = {1'b0, size_r};
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = (state == RD_ADDR);
  assign rready  = (state == RD_DATA);

  assign awid    = DATA_ID;
  assign awaddr  = addr_r;
  assign awlen   = 4'd0;
  assign awsize  = {1'b0, size_r};
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign awvalid = (state == WR_ADDR) && !aw_done;
  assign wid     = DATA_ID;
  assign wdata   = wdata_r;
  assign wstrb   = wstrb_r;
  assign wlast   = 1'b1;
  assign wvalid  = (state == WR_ADDR) && !w_done;
  assign bready  = (state == WR_RESP);

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  assign inst_data_ok = (state == DONE) && !owner_data;
  assign data_data_ok = (state == DONE) && owner_data;
  assign inst_rdata   = inst_rdata_r;
  assign data_rdata   = data_rdata_r;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept_data)      state_nxt = data_wr ? WR_ADDR : RD_ADDR;
        else if (accept_inst) state_nxt = RD_ADDR;
      end
      RD_ADDR: if (arready) state_nxt = RD_DATA;
      RD_DATA: if (rvalid)  state_nxt = DONE;
      // AW and W may complete in either order or together.
      WR_ADDR: if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = WR_RESP;
      WR_RESP: if (bvalid)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      owner_data   <= 1'b0;
      addr_r       <= 32'd0;
      size_r       <= 2'd0;
      wr_r         <= 1'b0;
      wstrb_r      <= 4'd0;
      wdata_r      <= 32'd0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      inst_rdata_r <= 32'd0;
      data_rdata_r <= 32'd0;
    end else begin
      state <= state_nxt;
      if (accept_data) begin
        owner_data <= 1'b1;
        addr_r     <= data_addr;
        size_r     <= data_size;
        wr_r       <= data_wr;
        wstrb_r    <= data_wstrb;
        wdata_r    <= data_wdata;
        aw_done    <= 1'b0;
        w_done     <= 1'b0;
      end else if (accept_inst) begin
        owner_data <= 1'b0;
        addr_r     <= inst_addr;
        size_r     <= 2'd2;
        wr_r       <= 1'b0;
        wstrb_r    <= 4'd0;
        wdata_r    <= 32'd0;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if ((state == RD_DATA) && rvalid) begin
        if (owner_data) data_rdata_r <= rdata;
        else            inst_rdata_r <= rdata;
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_bridge.sv
// Directed cycle-by-cycle bench: inputs driven 1ns after posedge, outputs checked 1ns later.
module tb_axi_sram_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [3:0]  arid, arlen, arcache;
  logic [31:0] araddr;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, arlock;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [3:0]  awid, awlen, awcache;
  logic [31:0] awaddr;
  logic [2:0]  awsize, awprot;
  logic [1:0]  awburst, awlock;
  logic        awvalid, awready;
  logic [3:0]  wid, wstrb;
  logic [31:0] wdata;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  axi_sram_bridge dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to the drive point of the next cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_in();
    inst_req = 0; inst_addr = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wstrb = 0; data_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
  endtask

  initial begin
    clear_in();
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    settle();
    // reset state
    chk("rst_arvalid", {31'd0, arvalid}, 0);
    chk("rst_awvalid", {31'd0, awvalid}, 0);
    chk("rst_wvalid",  {31'd0, wvalid},  0);
    chk("rst_rready",  {31'd0, rready},  0);
    chk("rst_bready",  {31'd0, bready},  0);
    chk("rst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 0);
    chk("rst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 0);
    chk("rst_inst_rdata", inst_rdata, 0);
    chk("rst_data_rdata", data_rdata, 0);

    // T1: zero-wait inst read
    tick();
    inst_req = 1; inst_addr = 32'hBFC00000;
    arready = 1; rvalid = 1; rdata = 32'h3C1D0001;
    settle();
    chk("t1_c0_addr_ok", {31'd0, inst_addr_ok}, 1);
    chk("t1_c0_arvalid", {31'd0, arvalid}, 0);
    tick(); inst_req = 0; inst_addr = 32'hDEAD0000; settle();
    chk("t1_c1_arvalid", {31'd0, arvalid}, 1);
    chk("t1_c1_araddr",  araddr, 32'hBFC00000);
    chk("t1_c1_arid",    {28'd0, arid}, 0);
    chk("t1_c1_arsize",  {29'd0, arsize}, 2);
    chk("t1_c1_arlen",   {28'd0, arlen}, 0);
    chk("t1_c1_arburst", {30'd0, arburst}, 1);
    chk("t1_c1_data_ok", {31'd0, inst_data_ok}, 0);
    tick(); settle();
    chk("t1_c2_rready",  {31'd0, rready}, 1);
    chk("t1_c2_arvalid", {31'd0, arvalid}, 0);
    chk("t1_c2_data_ok", {31'd0, inst_data_ok}, 0);
    tick(); rvalid = 0; settle();
    chk("t1_c3_data_ok", {31'd0, inst_data_ok}, 1);
    chk("t1_c3_rdata",   inst_rdata, 32'h3C1D0001);
    chk("t1_c3_ddok",    {31'd0, data_data_ok}, 0);
    tick(); settle();
    chk("t1_c4_data_ok", {31'd0, inst_data_ok}, 0);
    chk("t1_c4_rdata_hold", inst_rdata, 32'h3C1D0001);
    clear_in();

    // T2: halfword write, bvalid one cycle late
    tick();
    data_req = 1; data_wr = 1; data_size = 1; data_addr = 32'h00001004;
    data_wdata = 32'hAABBCCDD; data_wstrb = 4'h3;
    awready = 1; wready = 1;
    settle();
    chk("t2_c0_daddr_ok", {31'd0, data_addr_ok}, 1);
    chk("t2_c0_iaddr_ok", {31'd0, inst_addr_ok}, 0);
    tick(); data_req = 0; data_wdata = 0; settle();
    chk("t2_c1_awvalid", {31'd0, awvalid}, 1);
    chk("t2_c1_wvalid",  {31'd0, wvalid}, 1);
    chk("t2_c1_awaddr",  awaddr, 32'h00001004);
    chk("t2_c1_awsize",  {29'd0, awsize}, 1);
    chk("t2_c1_wstrb",   {28'd0, wstrb}, 3);
    chk("t2_c1_wdata",   wdata, 32'hAABBCCDD);
    chk("t2_c1_ids",     {24'd0, awid, wid}, 32'h11);
    chk("t2_c1_wlast",   {31'd0, wlast}, 1);
    chk("t2_c1_bready",  {31'd0, bready}, 0);
    tick(); awready = 0; wready = 0; settle();
    chk("t2_c2_bready",  {31'd0, bready}, 1);
    chk("t2_c2_valids",  {30'd0, awvalid, wvalid}, 0);
    tick(); bvalid = 1; settle();
    chk("t2_c3_bready",  {31'd0, bready}, 1);
    chk("t2_c3_data_ok", {31'd0, data_data_ok}, 0);
    tick(); bvalid = 0; settle();
    chk("t2_c4_data_ok", {31'd0, data_data_ok}, 1);
    tick(); settle();
    chk("t2_c5_data_ok", {31'd0, data_data_ok}, 0);
    clear_in();

    // T3: simultaneous requests, data first
    tick();
    data_req = 1; data_addr = 32'h00002000; data_size = 2;
    inst_req = 1; inst_addr = 32'h00003000;
    arready = 1; rvalid = 1; rdata = 32'h11112222;
    settle();
    chk("t3_c0_daddr_ok", {31'd0, data_addr_ok}, 1);
    chk("t3_c0_iaddr_ok", {31'd0, inst_addr_ok}, 0);
    tick(); data_req = 0; settle();
    chk("t3_c1_arid",     {28'd0, arid}, 1);
    chk("t3_c1_araddr",   araddr, 32'h00002000);
    chk("t3_c1_iaddr_ok", {31'd0, inst_addr_ok}, 0);
    tick(); settle();
    tick(); rdata = 32'h55556666; settle();
    chk("t3_c3_ddok",     {31'd0, data_data_ok}, 1);
    chk("t3_c3_drdata",   data_rdata, 32'h11112222);
    chk("t3_c3_iaddr_ok", {31'd0, inst_addr_ok}, 0);
    tick(); settle();
    chk("t3_c4_iaddr_ok", {31'd0, inst_addr_ok}, 1);
    tick(); inst_req = 0; settle();
    chk("t3_c5_arid",     {28'd0, arid}, 0);
    chk("t3_c5_araddr",   araddr, 32'h00003000);
    tick(); settle();
    tick(); settle();
    chk("t3_c7_idok",     {31'd0, inst_data_ok}, 1);
    chk("t3_c7_irdata",   inst_rdata, 32'h55556666);
    chk("t3_c7_drdata",   data_rdata, 32'h11112222);
    clear_in();

    // T4: arready stalled 3 cycles
    tick();
    inst_req = 1; inst_addr = 32'h00004000;
    settle();
    chk("t4_c0_addr_ok", {31'd0, inst_addr_ok}, 1);
    tick(); inst_req = 0; settle();
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("t4_c%0d_arvalid", i), {31'd0, arvalid}, 1);
      chk($sformatf("t4_c%0d_araddr", i), araddr, 32'h00004000);
      chk($sformatf("t4_c%0d_rready", i), {31'd0, rready}, 0);
      if (i < 3) begin tick(); settle(); end
    end
    tick(); arready = 1; settle();
    chk("t4_c4_arvalid", {31'd0, arvalid}, 1);
    chk("t4_c4_araddr",  araddr, 32'h00004000);
    tick(); arready = 0; rvalid = 1; rdata = 32'h0BADF00D; settle();
    chk("t4_c5_rready",  {31'd0, rready}, 1);
    chk("t4_c5_arvalid", {31'd0, arvalid}, 0);
    tick(); rvalid = 0; settle();
    chk("t4_c6_idok",    {31'd0, inst_data_ok}, 1);
    chk("t4_c6_rdata",   inst_rdata, 32'h0BADF00D);
    clear_in();

    // T5a: W handshake 2 cycles before AW
    tick();
    data_req = 1; data_wr = 1; data_size = 2; data_addr = 32'h00005000;
    data_wdata = 32'h12345678; data_wstrb = 4'hF;
    settle();
    chk("t5a_c0_daddr_ok", {31'd0, data_addr_ok}, 1);
    tick(); data_req = 0; wready = 1; settle();
    chk("t5a_c1_valids", {30'd0, awvalid, wvalid}, 3);
    tick(); wready = 0; settle();
    chk("t5a_c2_valids", {30'd0, awvalid, wvalid}, 2);
    chk("t5a_c2_bready", {31'd0, bready}, 0);
    tick(); awready = 1; settle();
    chk("t5a_c3_valids", {30'd0, awvalid, wvalid}, 2);
    chk("t5a_c3_bready", {31'd0, bready}, 0);
    tick(); awready = 0; bvalid = 1; settle();
    chk("t5a_c4_valids", {30'd0, awvalid, wvalid}, 0);
    chk("t5a_c4_bready", {31'd0, bready}, 1);
    tick(); bvalid = 0; settle();
    chk("t5a_c5_ddok",   {31'd0, data_data_ok}, 1);
    clear_in();

    // T5b: AW handshake 2 cycles before W
    tick();
    data_req = 1; data_wr = 1; data_size = 0; data_addr = 32'h00005003;
    data_wdata = 32'h000000EE; data_wstrb = 4'h8;
    settle();
    chk("t5b_c0_daddr_ok", {31'd0, data_addr_ok}, 1);
    tick(); data_req = 0; awready = 1; settle();
    chk("t5b_c1_valids", {30'd0, awvalid, wvalid}, 3);
    chk("t5b_c1_awsize", {29'd0, awsize}, 0);
    tick(); awready = 0; settle();
    chk("t5b_c2_valids", {30'd0, awvalid, wvalid}, 1);
    chk("t5b_c2_bready", {31'd0, bready}, 0);
    tick(); wready = 1; settle();
    chk("t5b_c3_valids", {30'd0, awvalid, wvalid}, 1);
    chk("t5b_c3_wstrb",  {28'd0, wstrb}, 8);
    chk("t5b_c3_bready", {31'd0, bready}, 0);
    tick(); wready = 0; bvalid = 1; settle();
    chk("t5b_c4_valids", {30'd0, awvalid, wvalid}, 0);
    chk("t5b_c4_bready", {31'd0, bready}, 1);
    tick(); bvalid = 0; settle();
    chk("t5b_c5_ddok",   {31'd0, data_data_ok}, 1);
    clear_in();

    // T6: reset during RD_DATA
    tick();
    inst_req = 1; inst_addr = 32'h00006000; arready = 1;
    settle();
    chk("t6_c0_addr_ok", {31'd0, inst_addr_ok}, 1);
    tick(); inst_req = 0; settle();
    tick(); arready = 0; settle();
    chk("t6_c2_rready", {31'd0, rready}, 1);
    reset = 1;
    settle();
    chk("t6_rst_rready",  {31'd0, rready}, 0);
    chk("t6_rst_arvalid", {31'd0, arvalid}, 0);
    tick(); rvalid = 1; rdata = 32'hFFFFFFFF; settle();
    chk("t6_rst_idok",    {31'd0, inst_data_ok}, 0);
    chk("t6_rst_rready2", {31'd0, rready}, 0);
    chk("t6_rst_irdata",  inst_rdata, 0);
    tick(); rvalid = 0; reset = 0; inst_req = 1; inst_addr = 32'h00007000; arready = 1;
    settle();
    chk("t6_post_addr_ok", {31'd0, inst_addr_ok}, 1);
    tick(); inst_req = 0; rvalid = 1; rdata = 32'h77778888; settle();
    chk("t6_post_araddr", araddr, 32'h00007000);
    tick(); settle();
    tick(); rvalid = 0; settle();
    chk("t6_post_idok",   {31'd0, inst_data_ok}, 1);
    chk("t6_post_rdata",  inst_rdata, 32'h77778888);
    clear_in();

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_sram_bridge.md
Name: axi_sram_bridge

Overview:
- Downstream of the MiniMIPS32 core inside the CPU top; replaces direct SRAM hookup.
- Converts two SRAM-like request ports into AXI3 master transactions:
  - instruction port: read-only;
  - data port: read/write.
- One outstanding transaction at a time, with fixed arbitration (data over inst).
- AXI port names and widths match the CPU top's AXI interface so they wire straight through.

Parameters:
- INST_ID, 4'd0, AXI ID driven on arid for instruction reads.
- DATA_ID, 4'd1, AXI ID driven on arid/awid/wid for data accesses.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- inst_req  in  1  instruction read request
- inst_addr  in  32  physical fetch address
- inst_addr_ok  out  1  request accepted this cycle
- inst_data_ok  out  1  one-cycle pulse, inst_rdata valid
- inst_rdata  out  32  fetched word
- data_req  in  1  data request
- data_wr  in  1  1=write, 0=read
- data_size  in  2  0=byte, 1=half, 2=word
- data_addr  in  32  physical data address
- data_wstrb  in  4  byte enables for writes
- data_wdata  in  32  write data
- data_addr_ok  out  1  request accepted this cycle
- data_data_ok  out  1  one-cycle pulse, read data valid or write done
- data_rdata  out  32  load word
- AR channel: arid 4, araddr 32, arlen 4, arsize 3, arburst 2, arlock 2, arcache 4, arprot 3, arvalid 1 (out); arready 1 (in)
- R channel: rid 4, rdata 32, rresp 2, rlast 1, rvalid 1 (in); rready 1 (out)
- AW channel: awid 4, awaddr 32, awlen 4, awsize 3, awburst 2, awlock 2, awcache 4, awprot 3, awvalid 1 (out); awready 1 (in)
- W channel: wid 4, wdata 32, wstrb 4, wlast 1, wvalid 1 (out); wready 1 (in)
- B channel: bid 4, bresp 2, bvalid 1 (in); bready 1 (out)

Behaviour:
- Reset values: state=IDLE; all valid/ready outputs 0; *_addr_ok 0, *_data_ok 0; latched address, data and rdata registers 0.
- Constant AXI fields:
  - arlen=awlen=0; arburst=awburst=2'b01; lock, cache and prot all 0; wlast=1.
  - arsize=awsize={1'b0,size}.
  - awid=wid=DATA_ID; arid = INST_ID or DATA_ID per owner.
- States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP, DONE.
- IDLE arbitration:
  - data_req has priority: data_addr_ok=1 combinationally; inst_addr_ok=0 that cycle.
  - Else inst_req gives inst_addr_ok=1.
  - addr_ok is only ever 1 in IDLE.
  - On accept, latch addr, size, wr, wstrb, wdata and owner.
  - Next state: data write -> WR_ADDR; any read -> RD_ADDR.
- RD_ADDR: arvalid=1 with stable fields; on arvalid&arready -> RD_DATA, arvalid=0 next cycle.
- RD_DATA: rready=1; on rvalid -> latch rdata into owner's rdata register -> DONE.
  - rid, rresp and rlast are ignored.
- WR_ADDR: awvalid and wvalid both raised on entry.
  - Each drops independently after its own handshake; track with aw_done/w_done flags.
  - When both are complete (same or different cycles) -> WR_RESP.
- WR_RESP: bready=1; on bvalid -> DONE. bresp is ignored.
- DONE: owner's data_ok=1 for exactly one cycle; rdata is valid that cycle and held until the next fill; then -> IDLE.
  - No accept occurs in DONE, so there is no back-to-back overlap.
- Minimum latency with zero-wait slave:
  - read: addr_ok at cycle 0, data_ok at cycle 3;
  - write: data_ok at cycle 3.
- Never more than one AXI transaction outstanding, so no read-after-write hazard handling is needed.
- Reset mid-transaction: state returns to IDLE immediately and all valids drop; the in-flight request is lost. The SoC resets the slave together with the bridge.
- Requester contract: inputs are sampled only on the addr_ok cycle; later changes are ignored.

Test Plan:
- Inst read 0xBFC00000, slave zero-wait returning 0x3C1D0001 -> inst_addr_ok at cycle 0, arvalid cycle 1, arid=0, arsize=2, inst_data_ok=1 and inst_rdata=0x3C1D0001 at cycle 3 only.
- Data write addr 0x00001004, wdata 0xAABBCCDD, wstrb 0x3, size 1 -> awaddr=0x00001004, awsize=1, wstrb=0x3, awid=wid=1, wlast=1, data_data_ok pulses one cycle after bvalid.
- inst_req and data_req both high in IDLE -> only data_addr_ok=1; inst is served after data_data_ok; inst_addr_ok appears in the following IDLE cycle.
- arready held low for 3 cycles -> arvalid stays 1 with stable araddr for 4 cycles; no rready before the handshake.
- Write with wready 2 cycles before awready, then the reverse order -> each valid drops after its own handshake; bready is asserted only after both are done.
- reset asserted during RD_DATA -> next edge arvalid=rready=0, no data_ok; a new inst_req gets inst_addr_ok the first cycle after reset deassertion.
